clock_ctrl: RTL and testbench

//  Time-of-day sequencer for the clock subsystem. Drives the stop input of the

---
 rtl/clock_pkg.sv | 19 +
 rtl/mod_counter.sv | 31 +++
 rtl/clock_ctrl.sv | 104 ++++++++++
 tb/tb_clock_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and default dimensions for the time-of-day clock controller.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    PAUSE    = 2'd1,
    SET_HOUR = 2'd2,
    SET_MIN  = 2'd3
  } state_t;

  localparam int c_hours   = 24;
  localparam int c_minutes = 60;
  localparam int c_seconds = 60;

  localparam int hour_w = $clog2(c_hours);
  localparam int min_w  = $clog2(c_minutes);
  localparam int sec_w  = $clog2(c_seconds);

endpackage

// File: rtl/mod_counter.sv
// Modulo-p_mod counter with enable and synchronous clear; o_wrap flags the
// enabled step from p_mod-1 back to 0 so counters can be chained.
module mod_counter #(
  parameter int p_mod = 60
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_en,
  input  logic                     i_clr,
  output logic [$clog2(p_mod)-1:0] o_cnt,
  output logic                     o_wrap
);

  localparam int w = $clog2(p_mod);
  localparam logic [w-1:0] last = w'(p_mod - 1);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of its inputs regardless of order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cnt <= '0;
    end else if (i_clr) begin
      o_cnt <= '0;
    end else if (i_en) begin
      o_cnt <= (o_cnt == last) ? '0 : o_cnt + 1'b1;
    end
  end

  assign o_wrap = i_en && (o_cnt == last);

endmodule

// File: rtl/clock_ctrl.sv
// Time-of-day sequencer: RUN/PAUSE/SET mode machine, hh:mm:ss counters fed by
// the 1 Hz prescaler tick, prescaler stop control and a day-wrap pulse.
module clock_ctrl
  import clock_pkg::*;
#(
  parameter int p_hours   = c_hours,
  parameter int p_minutes = c_minutes,
  parameter int p_seconds = c_seconds
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_tick,
  input  logic                         i_mode,
  input  logic                         i_pause,
  input  logic                         i_inc,
  output logic                         o_stop,
  output logic [$clog2(p_seconds)-1:0] o_sec,
  output logic [$clog2(p_minutes)-1:0] o_min,
  output logic [$clog2(p_hours)-1:0]   o_hour,
  output logic [1:0]                   o_state,
  output logic                         o_day
);

  state_t state_q, state_d;
  logic   stop_q, day_q;
  logic   run, in_set_hour, in_set_min;
  logic   sec_en, sec_clr, min_en, hour_en;
  logic   sec_wrap, min_wrap, hour_wrap;

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (i_mode)       state_d = SET_HOUR;
        else if (i_pause) state_d = PAUSE;
      end
      PAUSE: begin
        if (i_mode)       state_d = SET_HOUR;
        else if (i_pause) state_d = RUN;
      end
      SET_HOUR: if (i_mode) state_d = SET_MIN;
      SET_MIN:  if (i_mode) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // NOTE: only control flops are reset here; the counters reset themselves.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= RUN;
      stop_q  <= 1'b0;
      day_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stop_q  <= (state_d != RUN);
      day_q   <= hour_wrap && run;
    end
  end

  assign run         = (state_q == RUN);
  assign in_set_hour = (state_q == SET_HOUR);
  assign in_set_min  = (state_q == SET_MIN);

  // Set-mode increments enter a counter directly; the carry into the next
  // field is only honoured while running, so setting never ripples upward.
  assign sec_en  = run && i_tick;
  assign sec_clr = in_set_min && i_mode;
  assign min_en  = sec_wrap || (in_set_min && i_inc);
  assign hour_en = (min_wrap && run) || (in_set_hour && i_inc);

  mod_counter #(.p_mod(p_seconds)) u_sec (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_en   (sec_en),
    .i_clr  (sec_clr),
    .o_cnt  (o_sec),
    .o_wrap (sec_wrap)
  );

  mod_counter #(.p_mod(p_minutes)) u_min (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_en   (min_en),
    .i_clr  (1'b0),
    .o_cnt  (o_min),
    .o_wrap (min_wrap)
  );

  mod_counter #(.p_mod(p_hours)) u_hour (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_en   (hour_en),
    .i_clr  (1'b0),
    .o_cnt  (o_hour),
    .o_wrap (hour_wrap)
  );

  assign o_state = state_q;
  assign o_stop  = stop_q;
  assign o_day   = day_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Self-checking bench for clock_ctrl: a vector table, directed corner-case
// sequences and random pulses compared against a seconds-of-day model.
module tb_clock_ctrl;
  import clock_pkg::*;

  localparam int day_secs = c_hours * c_minutes * c_seconds;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              tick = 1'b0, mode = 1'b0, pause = 1'b0, inc = 1'b0;
  logic              stop, day;
  logic [sec_w-1:0]  sec;
  logic [min_w-1:0]  min;
  logic [hour_w-1:0] hour;
  logic [1:0]        state;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: time held as seconds since midnight.
  state_t m_state;
  int     m_tod;
  bit     m_day;

  clock_ctrl dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_tick (tick),
    .i_mode (mode),
    .i_pause(pause),
    .i_inc  (inc),
    .o_stop (stop),
    .o_sec  (sec),
    .o_min  (min),
    .o_hour (hour),
    .o_state(state),
    .o_day  (day)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int m_hour();
    return m_tod / (c_minutes * c_seconds);
  endfunction
  function automatic int m_min();
    return (m_tod / c_seconds) % c_minutes;
  endfunction
  function automatic int m_sec();
    return m_tod % c_seconds;
  endfunction

  task automatic model_reset();
    m_state = RUN;
    m_tod   = 0;
    m_day   = 1'b0;
  endtask

  task automatic model_step(input bit t, input bit m, input bit p, input bit i);
    int h, mi;
    h  = m_hour();
    mi = m_min();
    m_day = 1'b0;
    case (m_state)
      RUN: begin
        if (t) begin
          m_tod = (m_tod + 1) % day_secs;
          m_day = (m_tod == 0);
        end
        if (m)      m_state = SET_HOUR;
        else if (p) m_state = PAUSE;
      end
      PAUSE: begin
        if (m)      m_state = SET_HOUR;
        else if (p) m_state = RUN;
      end
      SET_HOUR: begin
        if (i) m_tod += (((h + 1) % c_hours) - h) * c_minutes * c_seconds;
        if (m) m_state = SET_MIN;
      end
      default: begin
        if (i) m_tod += (((mi + 1) % c_minutes) - mi) * c_seconds;
        if (m) begin
          m_tod   -= m_tod % c_seconds;
          m_state = RUN;
        end
      end
    endcase
  endtask

  task automatic apply(input bit t, input bit m, input bit p, input bit i);
    @(negedge clk);
    tick = t; mode = m; pause = p; inc = i;
    @(posedge clk);
    #1;
    tick = 1'b0; mode = 1'b0; pause = 1'b0; inc = 1'b0;
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".state"}, 32'(state), 32'(m_state));
    check({tag, ".stop"},  32'(stop),  32'(m_state != RUN));
    check({tag, ".sec"},   32'(sec),   32'(m_sec()));
    check({tag, ".min"},   32'(min),   32'(m_min()));
    check({tag, ".hour"},  32'(hour),  32'(m_hour()));
    check({tag, ".day"},   32'(day),   32'(m_day));
  endtask

  task automatic step(input string tag, input bit t, input bit m, input bit p, input bit i);
    apply(t, m, p, i);
    model_step(t, m, p, i);
    compare_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Walk the set modes to hh:mm, leaving RUN with seconds cleared.
  task automatic set_time(input int h, input int mi);
    int n;
    step("set.enter", 1'b0, 1'b1, 1'b0, 1'b0);
    n = (h - m_hour() + c_hours) % c_hours;
    for (int k = 0; k < n; k++) step("set.hour", 1'b0, 1'b0, 1'b0, 1'b1);
    step("set.to_min", 1'b0, 1'b1, 1'b0, 1'b0);
    n = (mi - m_min() + c_minutes) % c_minutes;
    for (int k = 0; k < n; k++) step("set.min", 1'b0, 1'b0, 1'b0, 1'b1);
    step("set.exit", 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  typedef struct {
    bit t, m, p, i;
    state_t st;
    int     s, mi, h;
    bit     stp, dy;
  } vec_t;

  vec_t vecs[13];

  initial begin
    // Hand-derived sequence starting from 00:00:00 in RUN.
    vecs[0]  = '{1, 0, 0, 0, RUN,      1, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 1, 0, PAUSE,    1, 0, 0, 1, 0};
    vecs[2]  = '{1, 0, 0, 0, PAUSE,    1, 0, 0, 1, 0};
    vecs[3]  = '{0, 0, 0, 1, PAUSE,    1, 0, 0, 1, 0};
    vecs[4]  = '{0, 1, 1, 0, SET_HOUR, 1, 0, 0, 1, 0};
    vecs[5]  = '{1, 0, 0, 1, SET_HOUR, 1, 0, 1, 1, 0};
    vecs[6]  = '{0, 1, 0, 1, SET_MIN,  1, 0, 2, 1, 0};
    vecs[7]  = '{0, 0, 0, 1, SET_MIN,  1, 1, 2, 1, 0};
    vecs[8]  = '{0, 0, 1, 0, SET_MIN,  1, 1, 2, 1, 0};
    vecs[9]  = '{0, 1, 0, 0, RUN,      0, 1, 2, 0, 0};
    vecs[10] = '{1, 1, 0, 0, SET_HOUR, 1, 1, 2, 1, 0};
    vecs[11] = '{0, 1, 0, 0, SET_MIN,  1, 1, 2, 1, 0};
    vecs[12] = '{0, 1, 0, 0, RUN,      0, 1, 2, 0, 0};

    #3;
    check("reset.state", 32'(state), 32'(RUN));
    check("reset.stop",  32'(stop),  0);
    check("reset.time",  32'({hour, min, sec}), 0);
    check("reset.day",   32'(day),   0);
    #4;
    rst_n = 1'b1;

    for (int k = 0; k < 13; k++) begin
      apply(vecs[k].t, vecs[k].m, vecs[k].p, vecs[k].i);
      check($sformatf("vec%0d.state", k), 32'(state), 32'(vecs[k].st));
      check($sformatf("vec%0d.sec", k),   32'(sec),   32'(vecs[k].s));
      check($sformatf("vec%0d.min", k),   32'(min),   32'(vecs[k].mi));
      check($sformatf("vec%0d.hour", k),  32'(hour),  32'(vecs[k].h));
      check($sformatf("vec%0d.stop", k),  32'(stop),  32'(vecs[k].stp));
      check($sformatf("vec%0d.day", k),   32'(day),   32'(vecs[k].dy));
    end

    // 61 ticks from reset roll one minute.
    do_reset();
    for (int k = 0; k < 61; k++) step("run61", 1'b1, 1'b0, 1'b0, 1'b0);
    check("run61.hms", 32'({hour, min, sec}), 32'({5'd0, 6'd1, 6'd1}));

    // Preset 23:59:58 and roll over midnight.
    set_time(23, 59);
    check("preset.sec_cleared", 32'(sec), 0);
    for (int k = 0; k < 58; k++) step("preset.run", 1'b1, 1'b0, 1'b0, 1'b0);
    step("wrap.t1", 1'b1, 1'b0, 1'b0, 1'b0);
    check("wrap.pre_day", 32'(day), 0);
    step("wrap.t2", 1'b1, 1'b0, 1'b0, 1'b0);
    check("wrap.day", 32'(day), 1);
    check("wrap.hms", 32'({hour, min, sec}), 0);
    step("wrap.after", 1'b0, 1'b0, 1'b0, 1'b0);
    check("wrap.day_gone", 32'(day), 0);

    // Pause holds time through ticks; resume counts the next tick.
    step("pause.on", 1'b0, 1'b0, 1'b1, 1'b0);
    check("pause.stop", 32'(stop), 1);
    for (int k = 0; k < 5; k++) step("pause.tick", 1'b1, 1'b0, 1'b0, 1'b0);
    check("pause.held", 32'(sec), 0);
    step("pause.off", 1'b0, 1'b0, 1'b1, 1'b0);
    check("pause.stop_off", 32'(stop), 0);
    step("pause.resume", 1'b1, 1'b0, 1'b0, 1'b0);
    check("pause.counted", 32'(sec), 1);

    // Set-mode increments wrap without carrying.
    set_time(23, 30);
    step("edge.sh", 1'b0, 1'b1, 1'b0, 1'b0);
    step("edge.hinc", 1'b0, 1'b0, 1'b0, 1'b1);
    check("edge.hour_wrap", 32'({hour, min}), 32'({5'd0, 6'd30}));
    step("edge.sm", 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 29; k++) step("edge.mset", 1'b0, 1'b0, 1'b0, 1'b1);
    step("edge.minc", 1'b0, 1'b0, 1'b0, 1'b1);
    check("edge.min_wrap", 32'({hour, min}), 32'({5'd0, 6'd0}));
    step("edge.exit", 1'b0, 1'b1, 1'b0, 1'b0);

    // Coincident pulses.
    step("co.run", 1'b1, 1'b0, 1'b0, 1'b0);
    step("co.tick_mode", 1'b1, 1'b1, 1'b0, 1'b0);
    check("co.sec", 32'(sec), 2);
    check("co.state", 32'(state), 32'(SET_HOUR));
    step("co.inc_mode", 1'b0, 1'b1, 1'b0, 1'b1);
    check("co.hour", 32'(hour), 1);
    check("co.state2", 32'(state), 32'(SET_MIN));
    step("co.exit", 1'b0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset between edges.
    for (int k = 0; k < 7; k++) step("ar.run", 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar.time", 32'({hour, min, sec}), 0);
    check("ar.state", 32'(state), 32'(RUN));
    check("ar.stop", 32'(stop), 0);
    #3;
    rst_n = 1'b1;
    model_reset();
    step("ar.resume", 1'b1, 1'b0, 1'b0, 1'b0);
    check("ar.resume_sec", 32'(sec), 1);

    // Random pulses against the model.
    for (int k = 0; k < 3000; k++) begin
      step("rand",
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
